// File: rtl/cross_bar_pkg.sv
// Shared types and configuration for the cross-bar arbitration logic.
package cross_bar_pkg;

    localparam int MASTER_N = 4;
    localparam int WEIGHT_W = 4;

    typedef logic [$clog2(MASTER_N)-1:0] master_idx_t;
    typedef logic [WEIGHT_W-1:0]         weight_t;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cross_bar_wrr_arbiter_if.sv
// Request/grant bundle between the cross-bar masters and the WRR arbiter.
interface cross_bar_wrr_arbiter_if #(
    parameter int REQ_N = cross_bar_pkg::MASTER_N
);
    import cross_bar_pkg::*;

    localparam int IDX_W = $clog2(REQ_N);

    logic [REQ_N-1:0]          req;
    logic [REQ_N-1:0]          last;
    logic [REQ_N*WEIGHT_W-1:0] weight;
    logic [REQ_N-1:0]          grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_valid;

    modport master (
        output req, last, weight,
        input  grant, grant_idx, grant_valid
    );

    modport slave (
        input  req, last, weight,
        output grant, grant_idx, grant_valid
    );

endinterface

// File: rtl/cross_bar_rr_pick.sv
// Combinational rotating find-first: first set bit of req_mask at or above
// start, wrapping modulo REQ_N.
module cross_bar_rr_pick #(
    parameter int REQ_N = 4,
    localparam int IDX_W = $clog2(REQ_N)
) (
    input  logic [REQ_N-1:0] req_mask,
    input  logic [IDX_W-1:0] start,
    output logic [REQ_N-1:0] pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             found
);

    logic [IDX_W:0]   pos_wide_s;
    logic [IDX_W-1:0] pos_s;

    // Walk the candidates in rotation order and keep the first requester.
    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        found      = 1'b0;
        pos_wide_s = '0;
        pos_s      = '0;
        for (int k = 0; k < REQ_N; k++) begin
            pos_wide_s = {1'b0, start} + (IDX_W+1)'(k);
            if (pos_wide_s >= (IDX_W+1)'(REQ_N)) begin
                pos_wide_s = pos_wide_s - (IDX_W+1)'(REQ_N);
            end else begin
                pos_wide_s = pos_wide_s;
            end
            pos_s = pos_wide_s[IDX_W-1:0];
            if (!found && req_mask[pos_s]) begin
                found       = 1'b1;
                pick[pos_s] = 1'b1;
                pick_idx    = pos_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/cross_bar_wrr_arbiter.sv
// Weighted round-robin arbiter with transaction locking. The owner keeps the
// grant until last; it may run weight+1 back-to-back transactions per turn.
module cross_bar_wrr_arbiter
    import cross_bar_pkg::*;
#(
    parameter int REQ_N = MASTER_N
) (
    input  logic                  clk,
    input  logic                  reset,
    cross_bar_wrr_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(REQ_N);

    arb_state_t       state_r, state_s;
    logic [REQ_N-1:0] grant_r, grant_s;
    logic [IDX_W-1:0] grant_idx_r, grant_idx_s;
    logic             grant_valid_r;
    logic [IDX_W-1:0] ptr_r, ptr_s;
    weight_t          credit_r, credit_s;

    weight_t          weight_s [REQ_N];
    logic [REQ_N-1:0] mask_s;
    logic [IDX_W-1:0] start_s;
    logic [REQ_N-1:0] pick_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             found_s;
    logic [IDX_W-1:0] owner_next_s;

    // Successor index with wrap from REQ_N-1 back to 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(REQ_N-1)) begin
            return '0;
        end else begin
            return i + IDX_W'(1);
        end
    endfunction

    for (genvar g = 0; g < REQ_N; g++) begin : g_weight
        assign weight_s[g] = bus.weight[g*WEIGHT_W +: WEIGHT_W];
    end

    assign owner_next_s = next_idx(grant_idx_r);

    // One picker serves both paths: from ptr when idle, from owner+1 (owner
    // excluded) while a grant is held.
    always_comb begin
        mask_s  = bus.req;
        start_s = ptr_r;
        if (state_r == ARB_GRANT) begin
            mask_s  = bus.req & ~grant_r;
            start_s = owner_next_s;
        end else begin
            mask_s  = bus.req;
            start_s = ptr_r;
        end
    end

    cross_bar_rr_pick #(.REQ_N(REQ_N)) u_pick (
        .req_mask (mask_s),
        .start    (start_s),
        .pick     (pick_s),
        .pick_idx (pick_idx_s),
        .found    (found_s)
    );

    // Next-state, next-grant, credit and pointer decisions.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        grant_idx_s = grant_idx_r;
        ptr_s       = ptr_r;
        credit_s    = credit_r;
        case (state_r)
            ARB_IDLE: begin
                if (found_s) begin
                    grant_s     = pick_s;
                    grant_idx_s = pick_idx_s;
                    credit_s    = weight_s[pick_idx_s];
                    state_s     = ARB_GRANT;
                end else begin
                    grant_s = '0;
                end
            end
            ARB_GRANT: begin
                if (!bus.req[grant_idx_r]) begin
                    // Owner released or aborted: hand over without a bubble.
                    if (found_s) begin
                        grant_s     = pick_s;
                        grant_idx_s = pick_idx_s;
                        credit_s    = weight_s[pick_idx_s];
                    end else begin
                        grant_s = '0;
                        ptr_s   = owner_next_s;
                        state_s = ARB_IDLE;
                    end
                end else if (bus.last[grant_idx_r]) begin
                    // Transaction boundary: spend credit, rotate, or reload.
                    if (credit_r != WEIGHT_W'(0)) begin
                        credit_s = credit_r - WEIGHT_W'(1);
                    end else if (found_s) begin
                        grant_s     = pick_s;
                        grant_idx_s = pick_idx_s;
                        credit_s    = weight_s[pick_idx_s];
                    end else begin
                        credit_s = weight_s[grant_idx_r];
                    end
                end else begin
                    credit_s = credit_r;
                end
            end
            default: begin
                state_s = ARB_IDLE;
                grant_s = '0;
            end
        endcase
    end

    // Arbitration state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ARB_IDLE;
            grant_r       <= '0;
            grant_idx_r   <= '0;
            grant_valid_r <= 1'b0;
            ptr_r         <= '0;
            credit_r      <= '0;
        end else begin
            state_r       <= state_s;
            grant_r       <= grant_s;
            grant_idx_r   <= grant_idx_s;
            grant_valid_r <= |grant_s;
            ptr_r         <= ptr_s;
            credit_r      <= credit_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_idx   = grant_idx_r;
    assign bus.grant_valid = grant_valid_r;

endmodule

// File: tb/tb_cross_bar_wrr_arbiter.sv
// Directed self-checking bench for cross_bar_wrr_arbiter (4 masters).
module tb_cross_bar_wrr_arbiter;

    localparam int REQ_N = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cross_bar_wrr_arbiter_if #(.REQ_N(REQ_N)) bus ();

    cross_bar_wrr_arbiter #(.REQ_N(REQ_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Owner o runs one transaction of len cycles with last on the final cycle.
    task automatic txn(input int o, input int len);
        logic [3:0] oh;
        oh = 4'b0001 << o;
        for (int c = 1; c <= len; c++) begin
            chk("txn_grant", 32'(bus.grant), 32'(oh));
            chk("txn_idx", 32'(bus.grant_idx), 32'(o));
            bus.last = (c == len) ? oh : 4'b0000;
            tick();
        end
        bus.last = 4'b0000;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        bus.req    = 4'hF;
        bus.last   = 4'h0;
        bus.weight = 16'h0000;

        // 1: reset held with all requests, then first grant to master 0
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_grant", 32'(bus.grant), 32'h0);
            chk("rst_valid", 32'(bus.grant_valid), 32'h0);
        end
        reset = 1'b0;
        tick();
        chk("first_grant", 32'(bus.grant), 32'h1);
        chk("first_idx", 32'(bus.grant_idx), 32'h0);
        chk("first_valid", 32'(bus.grant_valid), 32'h1);

        // 2: plain round robin, two cycles per owner
        for (int k = 0; k < 4; k++) begin
            txn(k, 2);
        end
        chk("rr_wrap", 32'(bus.grant), 32'h1);

        // 3: weight[0]=2 gives master 0 three transactions per turn
        bus.weight = 16'h0002;
        reset = 1'b1;
        tick();
        chk("w_rst_grant", 32'(bus.grant), 32'h0);
        reset = 1'b0;
        tick();
        txn(0, 4);
        txn(0, 4);
        txn(0, 4);
        txn(1, 4);
        chk("w_after", 32'(bus.grant), 32'h4);

        // 4: lone requester with last every cycle keeps the grant
        bus.req  = 4'b0100;
        bus.last = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lone_grant", 32'(bus.grant), 32'h4);
            chk("lone_valid", 32'(bus.grant_valid), 32'h1);
        end
        bus.last = 4'h0;

        // 5: release hands over to master 1 (wrap), mid-transaction drop
        bus.req = 4'b0010;
        tick();
        chk("rel_to1", 32'(bus.grant), 32'h2);
        tick();
        chk("hold1", 32'(bus.grant), 32'h2);
        bus.req = 4'b1001;
        tick();
        chk("drop_grant", 32'(bus.grant), 32'h8);
        chk("drop_idx", 32'(bus.grant_idx), 32'h3);
        bus.req = 4'b0000;
        tick();
        chk("idle_grant", 32'(bus.grant), 32'h0);
        chk("idle_valid", 32'(bus.grant_valid), 32'h0);
        chk("idle_idx_hold", 32'(bus.grant_idx), 32'h3);
        bus.req = 4'hF;
        tick();
        chk("ptr_wrap", 32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        tick();
        chk("idle2_grant", 32'(bus.grant), 32'h0);
        bus.req = 4'b1011;
        tick();
        chk("ptr_adv", 32'(bus.grant), 32'h2);
        chk("ptr_adv_idx", 32'(bus.grant_idx), 32'h1);

        // 6: reset while master 2 holds credit 3
        bus.weight = 16'h0302;
        bus.req    = 4'b0100;
        tick();
        chk("own2", 32'(bus.grant), 32'h4);
        tick();
        chk("own2_hold", 32'(bus.grant), 32'h4);
        reset   = 1'b1;
        bus.req = 4'hF;
        tick();
        chk("mid_rst_grant", 32'(bus.grant), 32'h0);
        chk("mid_rst_valid", 32'(bus.grant_valid), 32'h0);
        chk("mid_rst_idx", 32'(bus.grant_idx), 32'h0);
        reset = 1'b0;
        tick();
        txn(0, 1);
        txn(0, 1);
        txn(0, 1);
        chk("post_rst_rot", 32'(bus.grant), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
